// File: rtl/proc_pkg.sv
// Shared definitions for the bus-datapath control unit: opcodes, FSM states, IR field positions.
package proc_pkg;
   localparam int DATA_W_DEF = 16;
   localparam int NREG       = 8;

   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_MVNZ = 3'b100;

   localparam int OPC_HI = 15;
   localparam int OPC_LO = 13;
   localparam int RX_HI  = 12;
   localparam int RX_LO  = 10;
   localparam int RY_HI  = 9;
   localparam int RY_LO  = 7;

   typedef enum logic [1:0] {S_IDLE, S_T1, S_T2, S_T3} state_t;
endpackage

// File: rtl/proc_ctrl_if.sv
// Instruction-source / datapath-control signal bundle. The controller uses the slave
// modport; whoever drives run/din/g_nz uses master.
interface proc_ctrl_if import proc_pkg::*; #(parameter int DATA_W = DATA_W_DEF);
   logic              run;
   logic [DATA_W-1:0] din;
   logic              g_nz;
   logic              ir_ena;
   logic [NREG-1:0]   r_in;
   logic [NREG-1:0]   r_out;
   logic              din_out;
   logic              g_out;
   logic              A_ena;
   logic              G_ena;
   logic              Add_SubNot;
   logic              done;

   modport master (output run, din, g_nz,
                   input  ir_ena, r_in, r_out, din_out, g_out, A_ena, G_ena, Add_SubNot, done);
   modport slave  (input  run, din, g_nz,
                   output ir_ena, r_in, r_out, din_out, g_out, A_ena, G_ena, Add_SubNot, done);
endinterface

// File: rtl/proc_ctrl_dec3to8.sv
// 3-bit index to 8-bit one-hot decoder with enable; all-zero when disabled.
module dec3to8 (
   input  logic       en,
   input  logic [2:0] idx,
   output logic [7:0] y
);
   assign y = en ? (8'b1 << idx) : 8'b0;
endmodule

// File: rtl/proc_ctrl.sv
// Control FSM for the bus datapath: fetches into IR, then sequences register/ALU/bus enables.
// Define CMOV_EN to decode opcode 100 as mvnz (conditional move on g_nz); otherwise it is a no-op.
module proc_ctrl import proc_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   proc_ctrl_if.slave  bus
);
   state_t            st, st_nxt;
   logic [DATA_W-1:0] ir;
   logic [2:0]        opc, rx, ry, rin_idx, rout_idx;
   logic              rin_en, rout_en;
   logic [NREG-1:0]   r_in_oh, r_out_oh;
   logic              ir_ena, din_out, g_out, a_ena, g_ena, add_sub, done;
   logic              unused_bits;

   assign opc = ir[OPC_HI:OPC_LO];
   assign rx  = ir[RX_HI:RX_LO];
   assign ry  = ir[RY_HI:RY_LO];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st <= S_IDLE;
         ir <= '0;
      end else begin
         st <= st_nxt;
         if (ir_ena) ir <= bus.din;
      end
   end

   // Only one bus driver is ever selected per state, which keeps the bus arbitration trivially safe.
   always_comb begin
      st_nxt   = st;
      ir_ena   = 1'b0;
      rin_en   = 1'b0;
      rin_idx  = rx;
      rout_en  = 1'b0;
      rout_idx = ry;
      din_out  = 1'b0;
      g_out    = 1'b0;
      a_ena    = 1'b0;
      g_ena    = 1'b0;
      add_sub  = 1'b0;
      done     = 1'b0;
      case (st)
         S_IDLE: begin
            // rst_n gating keeps ir_ena low during reset even though run is a live input
            ir_ena = bus.run & rst_n;
            if (bus.run) st_nxt = S_T1;
         end
         S_T1: begin
            st_nxt = S_IDLE;
            case (opc)
               OP_MV: begin
                  rout_en = 1'b1;
                  rin_en  = 1'b1;
                  done    = 1'b1;
               end
               OP_MVI: begin
                  din_out = 1'b1;
                  rin_en  = 1'b1;
                  done    = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  rout_en  = 1'b1;
                  rout_idx = rx;
                  a_ena    = 1'b1;
                  st_nxt   = S_T2;
               end
`ifdef CMOV_EN
               OP_MVNZ: begin
                  rout_en = bus.g_nz;
                  rin_en  = bus.g_nz;
                  done    = 1'b1;
               end
`endif
               default: done = 1'b1;
            endcase
         end
         S_T2: begin
            rout_en = 1'b1;
            g_ena   = 1'b1;
            add_sub = (opc == OP_ADD);
            st_nxt  = S_T3;
         end
         S_T3: begin
            g_out  = 1'b1;
            rin_en = 1'b1;
            done   = 1'b1;
            st_nxt = S_IDLE;
         end
         default: st_nxt = S_IDLE;
      endcase
   end

   dec3to8 u_rin  (.en(rin_en),  .idx(rin_idx),  .y(r_in_oh));
   dec3to8 u_rout (.en(rout_en), .idx(rout_idx), .y(r_out_oh));

   assign bus.ir_ena     = ir_ena;
   assign bus.r_in       = r_in_oh;
   assign bus.r_out      = r_out_oh;
   assign bus.din_out    = din_out;
   assign bus.g_out      = g_out;
   assign bus.A_ena      = a_ena;
   assign bus.G_ena      = g_ena;
   assign bus.Add_SubNot = add_sub;
   assign bus.done       = done;

`ifdef CMOV_EN
   assign unused_bits = ^ir[RY_LO-1:0];
`else
   assign unused_bits = ^{ir[RY_LO-1:0], bus.g_nz};
`endif
endmodule

// File: tb/tb_proc_ctrl.sv
// Bench for proc_ctrl: per-cycle expected control vectors are queued and popped against the DUT,
// with a behavioural register file / ALU attached to check end-to-end results.
module tb_proc_ctrl;
   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;

   proc_ctrl_if #(.DATA_W(16)) bus ();

   proc_ctrl #(.DATA_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // attached datapath
   logic [15:0] rf [8];
   logic [15:0] a_r, g_r, dbus;

   always_comb begin
      dbus = 16'h0;
      if (bus.din_out) dbus = bus.din;
      else if (bus.g_out) dbus = g_r;
      else for (int k = 0; k < 8; k++) if (bus.r_out[k]) dbus = rf[k];
   end

   always @(posedge clk) begin
      for (int j = 0; j < 8; j++) if (bus.r_in[j]) rf[j] <= dbus;
      if (bus.A_ena) a_r <= dbus;
      if (bus.G_ena) g_r <= bus.Add_SubNot ? a_r + dbus : a_r - dbus;
   end

   // {ir_ena, r_in, r_out, din_out, g_out, A_ena, G_ena, Add_SubNot, done}
   logic [22:0] sb [$];

   function automatic logic [22:0] ev(logic ire, logic [7:0] rin, logic [7:0] rout, logic dout,
                                      logic gout, logic ae, logic ge, logic as, logic dn);
      return {ire, rin, rout, dout, gout, ae, ge, as, dn};
   endfunction

   function automatic logic [22:0] outs();
      return {bus.ir_ena, bus.r_in, bus.r_out, bus.din_out, bus.g_out,
              bus.A_ena, bus.G_ena, bus.Add_SubNot, bus.done};
   endfunction

   task automatic cyc(input bit r, input logic [15:0] d);
      @(negedge clk);
      bus.run = r;
      bus.din = d;
      #1;
   endtask

   task automatic test_reset();
      logic [22:0] act;
      rst_n = 1'b0;
      bus.run = 1'b1;
      bus.din = 16'h2480;
      bus.g_nz = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      act = outs();
      n_chk++;
      if (act !== 23'h0) begin
         n_fail++;
         $display("FAIL reset_outs: got %h want %h", act, 23'h0);
      end
      bus.run = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_mvi();
      bit          rv [3];
      logic [15:0] dv [3];
      logic [22:0] act, exp_v;
      rv = '{1'b1, 1'b0, 1'b0};
      dv = '{16'h2480, 16'h0F00, 16'h0000};
      sb.push_back(ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
      sb.push_back(ev(0, 8'h02, 8'h00, 1, 0, 0, 0, 0, 1));
      sb.push_back(ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) begin
         cyc(rv[i], dv[i]);
         act = outs();
         exp_v = sb.pop_front();
         n_chk++;
         if (act !== exp_v) begin
            n_fail++;
            $display("FAIL mvi c%0d: got %h want %h", i, act, exp_v);
         end
      end
      n_chk++;
      if (rf[1] !== 16'h0F00) begin
         n_fail++;
         $display("FAIL mvi_r1: got %h want %h", rf[1], 16'h0F00);
      end
   endtask

   task automatic test_mv();
      bit          rv [3];
      logic [15:0] dv [3];
      logic [22:0] act, exp_v;
      rv = '{1'b1, 1'b0, 1'b0};
      dv = '{16'h0C80, 16'h0000, 16'h0000};
      sb.push_back(ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
      sb.push_back(ev(0, 8'h08, 8'h02, 0, 0, 0, 0, 0, 1));
      sb.push_back(ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) begin
         cyc(rv[i], dv[i]);
         act = outs();
         exp_v = sb.pop_front();
         n_chk++;
         if (act !== exp_v) begin
            n_fail++;
            $display("FAIL mv c%0d: got %h want %h", i, act, exp_v);
         end
         n_chk++;
         if ($countones({bus.r_out, bus.din_out, bus.g_out}) > 1) begin
            n_fail++;
            $display("FAIL mv_bus c%0d: got %0d drivers want <=1", i,
                     $countones({bus.r_out, bus.din_out, bus.g_out}));
         end
      end
      n_chk++;
      if (rf[3] !== 16'h0F00) begin
         n_fail++;
         $display("FAIL mv_r3: got %h want %h", rf[3], 16'h0F00);
      end
   endtask

   // mvi R2 with the immediate, then add/sub R1,R2; R1 must already hold its operand
   task automatic test_alu(input bit is_add, input logic [15:0] r2v, input logic [15:0] want);
      bit          rv [7];
      logic [15:0] dv [7];
      logic [22:0] act, exp_v;
      rv = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      dv = '{16'h2800, r2v, is_add ? 16'h4500 : 16'h6500, 16'h0, 16'h0, 16'h0, 16'h0};
      sb.push_back(ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
      sb.push_back(ev(0, 8'h04, 8'h00, 1, 0, 0, 0, 0, 1));
      sb.push_back(ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
      sb.push_back(ev(0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0));
      sb.push_back(ev(0, 8'h00, 8'h04, 0, 0, 0, 1, is_add, 0));
      sb.push_back(ev(0, 8'h02, 8'h00, 0, 1, 0, 0, 0, 1));
      sb.push_back(ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 7; i++) begin
         cyc(rv[i], dv[i]);
         act = outs();
         exp_v = sb.pop_front();
         n_chk++;
         if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s c%0d: got %h want %h", is_add ? "add" : "sub", i, act, exp_v);
         end
         n_chk++;
         if ($countones({bus.r_out, bus.din_out, bus.g_out}) > 1) begin
            n_fail++;
            $display("FAIL alu_bus c%0d: got %0d drivers want <=1", i,
                     $countones({bus.r_out, bus.din_out, bus.g_out}));
         end
      end
      n_chk++;
      if (rf[1] !== want) begin
         n_fail++;
         $display("FAIL %s_r1: got %h want %h", is_add ? "add" : "sub", rf[1], want);
      end
   endtask

   task automatic test_mvi_r1(input logic [15:0] v);
      bit          rv [3];
      logic [15:0] dv [3];
      logic [22:0] act, exp_v;
      rv = '{1'b1, 1'b0, 1'b0};
      dv = '{16'h2480, v, 16'h0000};
      sb.push_back(ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
      sb.push_back(ev(0, 8'h02, 8'h00, 1, 0, 0, 0, 0, 1));
      sb.push_back(ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) begin
         cyc(rv[i], dv[i]);
         act = outs();
         exp_v = sb.pop_front();
         n_chk++;
         if (act !== exp_v) begin
            n_fail++;
            $display("FAIL mvi_r1 c%0d: got %h want %h", i, act, exp_v);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit          rv [3];
      logic [15:0] dv [3];
      logic [22:0] act, exp_v;
      logic [15:0] r1_before;
      r1_before = rf[1];
      rv = '{1'b1, 1'b0, 1'b0};
      dv = '{16'h4500, 16'h0, 16'h0};
      sb.push_back(ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
      sb.push_back(ev(0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0));
      sb.push_back(ev(0, 8'h00, 8'h04, 0, 0, 0, 1, 1, 0));
      for (int i = 0; i < 3; i++) begin
         cyc(rv[i], dv[i]);
         act = outs();
         exp_v = sb.pop_front();
         n_chk++;
         if (act !== exp_v) begin
            n_fail++;
            $display("FAIL rstmid c%0d: got %h want %h", i, act, exp_v);
         end
      end
      rst_n = 1'b0;
      #1;
      act = outs();
      n_chk++;
      if (act !== 23'h0) begin
         n_fail++;
         $display("FAIL rstmid_async: got %h want %h", act, 23'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      act = outs();
      n_chk++;
      if (act !== 23'h0 || rf[1] !== r1_before) begin
         n_fail++;
         $display("FAIL rstmid_idle: got outs %h r1 %h want outs 0 r1 %h", act, rf[1], r1_before);
      end
      // illegal opcode after restart: done only
      rv = '{1'b1, 1'b0, 1'b0};
      dv = '{16'hE000, 16'h0, 16'h0};
      sb.push_back(ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
      sb.push_back(ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1));
      sb.push_back(ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) begin
         cyc(rv[i], dv[i]);
         act = outs();
         exp_v = sb.pop_front();
         n_chk++;
         if (act !== exp_v) begin
            n_fail++;
            $display("FAIL illegal c%0d: got %h want %h", i, act, exp_v);
         end
      end
   endtask

   task automatic test_mvnz();
      logic [22:0] act, exp_v;
      for (int g = 1; g >= 0; g--) begin
         bus.g_nz = g[0];
         sb.push_back(ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
`ifdef CMOV_EN
         if (g == 1) sb.push_back(ev(0, 8'h02, 8'h04, 0, 0, 0, 0, 0, 1));
         else        sb.push_back(ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1));
`else
         sb.push_back(ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1));
`endif
         sb.push_back(ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
         for (int i = 0; i < 3; i++) begin
            cyc(i == 0, i == 0 ? 16'h8500 : 16'h0000);
            act = outs();
            exp_v = sb.pop_front();
            n_chk++;
            if (act !== exp_v) begin
               n_fail++;
               $display("FAIL mvnz g%0d c%0d: got %h want %h", g, i, act, exp_v);
            end
         end
      end
      bus.g_nz = 1'b0;
   endtask

   task automatic test_back_to_back();
      bit          rv [5];
      logic [15:0] dv [5];
      logic [22:0] act, exp_v;
      rv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      dv = '{16'h2480, 16'h1234, 16'h0C80, 16'h0C80, 16'h0000};
      sb.push_back(ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
      sb.push_back(ev(0, 8'h02, 8'h00, 1, 0, 0, 0, 0, 1));
      sb.push_back(ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
      sb.push_back(ev(0, 8'h08, 8'h02, 0, 0, 0, 0, 0, 1));
      sb.push_back(ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 5; i++) begin
         cyc(rv[i], dv[i]);
         act = outs();
         exp_v = sb.pop_front();
         n_chk++;
         if (act !== exp_v) begin
            n_fail++;
            $display("FAIL b2b c%0d: got %h want %h", i, act, exp_v);
         end
      end
      n_chk++;
      if (rf[3] !== 16'h1234) begin
         n_fail++;
         $display("FAIL b2b_r3: got %h want %h", rf[3], 16'h1234);
      end
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      bus.run  = 1'b0;
      bus.din  = 16'h0;
      bus.g_nz = 1'b0;
      test_reset();
      test_mvi();
      test_mv();
      test_alu(1'b1, 16'h000F, 16'h0F0F);
      test_mvi_r1(16'h00F0);
      test_alu(1'b0, 16'h000F, 16'h00E1);
      test_reset_mid();
      test_mvnz();
      test_back_to_back();
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d left want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
